// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared ALU definitions used by the sequential multiplier:
//   - state_e    : multiplier FSM state encoding (IDLE/RUN/DONE)
//   - booth_op_e : radix-4 Booth operation selected by one multiplier triplet
//   - WIDTH_DEF  : default operand width
//   - booth_decode(): triplet {b[2i+1], b[2i], b[2i-1]} -> Booth operation
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_op_e;

  // Radix-4 Booth recoding of one overlapping multiplier triplet.
  function automatic booth_op_e booth_decode(input logic [2:0] trip);
    booth_op_e op;
    case (trip)
      3'b000:  op = ZERO;
      3'b001:  op = POS1;
      3'b010:  op = POS1;
      3'b011:  op = POS2;
      3'b100:  op = NEG2;
      3'b101:  op = NEG1;
      3'b110:  op = NEG1;
      3'b111:  op = ZERO;
      default: op = ZERO;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_recode_r4.sv
// ---------------------------------------------------------------------------
// booth_recode_r4
//   Combinational radix-4 Booth recoder.
//   Ports:
//     trip  in  3  multiplier triplet {b[2i+1], b[2i], b[2i-1]}
//     zero  out 1  partial product is 0
//     neg   out 1  subtract the selected multiple
//     two   out 1  selected multiple is 2*A (else 1*A)
// ---------------------------------------------------------------------------
module booth_recode_r4
  import alu_pkg::*;
(
  input  logic [2:0] trip,
  output logic       zero,
  output logic       neg,
  output logic       two
);

  booth_op_e op_s;

  // Decode the triplet into an operation, then into the adder control flags.
  always_comb begin
    op_s = booth_decode(trip);
    zero = 1'b0;
    neg  = 1'b0;
    two  = 1'b0;
    case (op_s)
      ZERO: zero = 1'b1;
      POS1: begin
        neg = 1'b0;
        two = 1'b0;
      end
      POS2: two = 1'b1;
      NEG1: neg = 1'b1;
      NEG2: begin
        neg = 1'b1;
        two = 1'b1;
      end
      default: zero = 1'b1;
    endcase
  end

endmodule

// File: rtl/mul32_booth_seq.sv
// ---------------------------------------------------------------------------
// mul32_booth_seq
//   Sequential signed WIDTH x WIDTH multiplier, radix-4 Booth, one recoded
//   digit per clock (WIDTH/2 cycles). Result layout {HI, LO}.
//   Ports:
//     clk    in   1        rising-edge clock
//     clr    in   1        asynchronous active-high reset
//     start  in   1        request, honoured only in IDLE or DONE
//     A      in   WIDTH    multiplicand (two's complement), sampled on accept
//     B      in   WIDTH    multiplier (two's complement), sampled on accept
//     busy   out  1        operation in progress (RUN)
//     done   out  1        one-cycle pulse, out is valid (DONE)
//     out    out  2*WIDTH  signed product, held until the next result
// ---------------------------------------------------------------------------
module mul32_booth_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam int ITER = WIDTH / 2;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int AW   = 2 * WIDTH + 3;  // {hi[WIDTH+1:0], lo[WIDTH-1:0], prev}
  localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

  state_e             state_r;
  state_e             state_s;
  logic               accept_s;
  logic               last_s;
  logic [CW-1:0]      count_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [AW-1:0]      acc_r;
  logic [AW-1:0]      acc_next_s;
  logic               busy_r;
  logic               done_r;
  logic [2*WIDTH-1:0] out_r;

  logic               zero_s;
  logic               neg_s;
  logic               two_s;
  logic [WIDTH+1:0]   hi_s;
  logic [WIDTH+1:0]   a_ext_s;
  logic [WIDTH+1:0]   addend_s;
  logic [WIDTH+1:0]   sum_s;

  booth_recode_r4 u_recode (
    .trip (acc_r[2:0]),
    .zero (zero_s),
    .neg  (neg_s),
    .two  (two_s)
  );

  assign last_s = (count_r == LAST_CNT);

  // Next-state logic; accept_s marks the edge that latches new operands.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s  = RUN;
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_s  = RUN;
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Booth step: add the selected multiple of A to the upper half (kept two
  // bits wider so +/-2A never overflows), then arithmetic-shift right by 2.
  always_comb begin
    hi_s     = acc_r[AW-1:WIDTH+1];
    a_ext_s  = {{2{mcand_r[WIDTH-1]}}, mcand_r};
    if (two_s) begin
      addend_s = {a_ext_s[WIDTH:0], 1'b0};
    end else begin
      addend_s = a_ext_s;
    end
    if (zero_s) begin
      sum_s = hi_s;
    end else if (neg_s) begin
      sum_s = hi_s - addend_s;
    end else begin
      sum_s = hi_s + addend_s;
    end
    // Bit 0 of the new accumulator is the old lo[1], i.e. the next b[2i-1].
    acc_next_s = {{2{sum_s[WIDTH+1]}}, sum_s, acc_r[WIDTH:2]};
  end

  // State register and registered handshake flags.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == RUN);
      done_r  <= (state_s == DONE);
    end
  end

  // Datapath: operand capture on accept, one Booth step per RUN cycle,
  // product captured only on the edge that enters DONE.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_r <= '0;
      mcand_r <= '0;
      acc_r   <= '0;
      out_r   <= '0;
    end else if (accept_s) begin
      count_r <= '0;
      mcand_r <= A;
      acc_r   <= {{(WIDTH + 2){1'b0}}, B, 1'b0};
    end else if (state_r == RUN) begin
      count_r <= count_r + CW'(1);
      acc_r   <= acc_next_s;
      if (last_s) begin
        out_r <= acc_next_s[2*WIDTH:1];
      end else begin
        out_r <= out_r;
      end
    end else begin
      count_r <= count_r;
      acc_r   <= acc_r;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign out  = out_r;

endmodule

// File: tb/tb_mul32_booth_seq.sv
module tb_mul32_booth_seq;

  logic        clk;
  logic        clr;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [63:0] out;

  int pass_cnt;
  int chk_cnt;

  mul32_booth_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // busy and done must never be high together.
  always @(negedge clk) begin
    if (!clr) begin
      chk_cnt++;
      assert (!(busy && done)) pass_cnt++;
      else $error("FAIL busy_done_excl observed=%b%b expected=not 11", busy, done);
    end
  end

  // One operation: returns the number of edges from accept to done.
  // pulse_at >= 0 raises start (with other operands) for one cycle mid-run.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string tag, input int pulse_at);
    int n;
    n = 0;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = $urandom; B = $urandom;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    while (!done && n < 40) begin
      if (n == pulse_at) begin
        start = 1'b1; A = 32'd2; B = 32'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check({tag, "_lat"}, 64'(n), 64'd16);
    check({tag, "_out"}, out, exp);
    @(posedge clk); #1;
    check({tag, "_donepulse"}, 64'(done), 64'd0);
    check({tag, "_hold"}, out, exp);
  endtask

  initial begin
    int n;
    longint sa;
    longint sb;
    logic [31:0] ra;
    logic [31:0] rb;
    pass_cnt = 0;
    chk_cnt  = 0;
    clr = 1'b1; start = 1'b0; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out", out, 64'd0);
    @(negedge clk);
    clr = 1'b0;

    // T1..T4 directed vectors
    run_op(32'd7, 32'd6, 64'h0000_0000_0000_002A, "t1", -1);
    run_op(32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, "t2", -1);
    run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "t3_min", -1);
    run_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, "t3_max", -1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "t4_m1", -1);
    run_op(32'd0, 32'h1234_5678, 64'h0000_0000_0000_0000, "t4_zero", -1);
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, "minmax", -1);

    // T5 start while busy is ignored
    run_op(32'd9, 32'd9, 64'd81, "t5", 5);

    // T6 clr mid-run clears immediately
    @(negedge clk);
    A = 32'd100; B = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    clr = 1'b1;
    #1;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check("t6_out", out, 64'd0);
    @(negedge clk);
    clr = 1'b0;
    run_op(32'd4, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF0, "t6_after", -1);

    // T7 back-to-back with start held high
    @(negedge clk);
    A = 32'd3; B = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    A = 32'd6; B = 32'd7;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("t7_lat1", 64'(n), 64'd16);
    check("t7_out1", out, 64'd15);
    n = 0;
    @(posedge clk); #1;
    n++;
    start = 1'b0;
    check("t7_rebusy", 64'(busy), 64'd1);
    check("t7_drop", 64'(done), 64'd0);
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("t7_gap", 64'(n), 64'd17);
    check("t7_out2", out, 64'd42);
    @(posedge clk); #1;

    // Random scoreboard
    for (int i = 0; i < 2000; i++) begin
      ra = $urandom;
      rb = $urandom;
      sa = longint'($signed(ra));
      sb = longint'($signed(rb));
      run_op(ra, rb, 64'(sa * sb), "rand", -1);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
